// File: rtl/fp_addsub_result_buffer_if.sv
// fp_addsub_result_buffer_if
//   Valid/ready result stream between the add/sub datapath, the result
//   buffer and its consumer.
//   in_*  : datapath -> buffer (in_ready flows back to the datapath)
//   out_* : buffer -> consumer (out_ready flows back to the buffer)
//   modport master : producer of in_* and consumer of out_* (datapath/consumer side)
//   modport slave  : the result buffer itself
`timescale 1ns/1ps

interface fp_addsub_result_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_mant;
  logic [4:0]  in_flags;   // {invalid,overflow,underflow,inexact,zero}
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_flags, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_flags, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_addsub_result_buffer.sv
// fp_addsub_result_buffer
//   Output stage of the single-precision add/sub datapath. Packs {sign,exp,mant}
//   into an IEEE-754 word (optionally canonicalising invalid results to the
//   default quiet NaN), queues word + flags in a DEPTH-entry FIFO and keeps a
//   sticky, software-clearable exception flag register.
//
//   Ports
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     bus         result stream (slave modport): in_* from the datapath,
//                 out_* to the consumer
//     fflags_clr  synchronous clear of fflags (a push in the same cycle
//                 still lands in fflags)
//     fflags      sticky OR of the flags of every accepted entry
//     count       current occupancy, 0..DEPTH
//
//   Occupancy FSM
//     state     | meaning
//     S_EMPTY   | count == 0, out_valid=0, in_ready=1
//     S_PARTIAL | 0 < count < DEPTH, out_valid=1, in_ready=1
//     S_FULL    | count == DEPTH, out_valid=1, in_ready=0
`timescale 1ns/1ps

module fp_addsub_result_buffer #(
  parameter int DEPTH     = 2,
  parameter bit CANON_NAN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fp_addsub_result_buffer_if.slave   bus,
  input  logic                       fflags_clr,
  output logic [4:0]                 fflags,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [31:0] QNAN_WORD = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } occ_state_t;

  occ_state_t      state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            in_ready_r;
  logic            out_valid_r;

  logic [31:0]     word_mem [DEPTH];
  logic [4:0]      flag_mem [DEPTH];

  logic            push;
  logic            pop;
  logic [31:0]     packed_word;

  // Handshakes only look at registered occupancy, so neither ready nor valid
  // has a combinational path through the buffer.
  assign push = bus.in_valid  & in_ready_r;
  assign pop  = out_valid_r   & bus.out_ready;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;

  // Stale RAM contents must never leak out while empty.
  assign bus.out_result = out_valid_r ? word_mem[rd_ptr] : 32'h0;
  assign bus.out_flags  = out_valid_r ? flag_mem[rd_ptr] : 5'h0;

  always_comb begin
    packed_word = {bus.in_sign, bus.in_exp, bus.in_mant};
    if (CANON_NAN && bus.in_flags[4]) begin
      packed_word = QNAN_WORD;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr] <= packed_word;
      flag_mem[wr_ptr] <= bus.in_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          // pop is impossible here; DEPTH >= 2 so one entry is never full
          if (push) begin
            wr_ptr      <= wr_ptr + PTR_ONE;
            count       <= CNT_ONE;
            state       <= S_PARTIAL;
            out_valid_r <= 1'b1;
          end
        end

        S_PARTIAL: begin
          case ({push, pop})
            2'b10: begin
              wr_ptr <= wr_ptr + PTR_ONE;
              count  <= count + CNT_ONE;
              if (count == CNT_LAST) begin
                state      <= S_FULL;
                in_ready_r <= 1'b0;
              end
            end
            2'b01: begin
              rd_ptr <= rd_ptr + PTR_ONE;
              count  <= count - CNT_ONE;
              if (count == CNT_ONE) begin
                state       <= S_EMPTY;
                out_valid_r <= 1'b0;
              end
            end
            2'b11: begin
              wr_ptr <= wr_ptr + PTR_ONE;
              rd_ptr <= rd_ptr + PTR_ONE;
            end
            default: begin
            end
          endcase
        end

        S_FULL: begin
          // push is impossible here (in_ready=0); only a pop can move us
          if (pop) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            count      <= CNT_LAST;
            state      <= S_PARTIAL;
            in_ready_r <= 1'b1;
          end
        end

        default: begin
          state       <= S_EMPTY;
          count       <= '0;
          wr_ptr      <= '0;
          rd_ptr      <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over history but not over a same-cycle push, so a flag raised
  // by the result being accepted while software clears is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags <= 5'h0;
    end else if (fflags_clr) begin
      fflags <= push ? bus.in_flags : 5'h0;
    end else if (push) begin
      fflags <= fflags | bus.in_flags;
    end
  end

endmodule

// File: tb/tb_fp_addsub_result_buffer.sv
`timescale 1ns/1ps

module tb_fp_addsub_result_buffer;
  localparam int DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic       fflags_clr;
  logic [4:0] fflags;
  logic [1:0] count;

  fp_addsub_result_buffer_if bus();

  fp_addsub_result_buffer #(.DEPTH(DEPTH), .CANON_NAN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fflags_clr (fflags_clr),
    .fflags     (fflags),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [36:0] sb[$];   // {flags, packed word}
  logic [4:0]  m_ff;

  bit          pp, pu;
  logic [31:0] gw, ew;
  logic [4:0]  gf, ef;

  function automatic logic [31:0] pack(input logic s, input logic [7:0] e,
                                       input logic [22:0] m, input logic [4:0] f);
    return f[4] ? 32'h7FC0_0000 : {s, e, m};
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] e,
                       input logic [22:0] m, input logic [4:0] f);
    bus.in_valid = v;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    bus.in_flags = f;
  endtask

  // Advances one clock: updates the reference model from the stimulus and
  // returns what the DUT presented at its head during this cycle.
  task automatic cycle(output bit popped, output bit pushed,
                       output logic [31:0] got_w, output logic [4:0] got_f,
                       output logic [31:0] exp_w, output logic [4:0] exp_f);
    logic [36:0] e;
    #1;
    pushed = bus.in_valid && (sb.size() < DEPTH);
    popped = (sb.size() != 0) && bus.out_ready;
    got_w  = bus.out_result;
    got_f  = bus.out_flags;
    exp_w  = '0;
    exp_f  = '0;
    if (popped) begin
      e = sb.pop_front();
      exp_f = e[36:32];
      exp_w = e[31:0];
    end
    if (fflags_clr) m_ff = pushed ? bus.in_flags : 5'b0;
    else if (pushed) m_ff = m_ff | bus.in_flags;
    if (pushed) sb.push_back({bus.in_flags, pack(bus.in_sign, bus.in_exp, bus.in_mant, bus.in_flags)});
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] fw(input int i);
    return {1'b0, 8'(8'h80 + i), 23'(i * 3 + 1)};
  endfunction

  function automatic logic [4:0] ff(input int i);
    return 5'(1 << (i % 4));
  endfunction

  task automatic test_reset();
    #1;
    total++;
    if (count !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || fflags !== 5'b0) begin
      bad++;
      $display("FAIL reset_init count=%0d in_ready=%b out_valid=%b fflags=%b required 0/1/0/00000",
               count, bus.in_ready, bus.out_valid, fflags);
    end
    total++;
    if (bus.out_result !== 32'h0 || bus.out_flags !== 5'h0) begin
      bad++;
      $display("FAIL reset_empty_out result=%h flags=%b required 0", bus.out_result, bus.out_flags);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h81, 23'h1, 5'b00100);
    cycle(pp, pu, gw, gf, ew, ef);
    drive(1'b1, 1'b1, 8'h82, 23'h2, 5'b00001);
    cycle(pp, pu, gw, gf, ew, ef);
    drive(1'b0, 1'b0, 8'h0, 23'h0, 5'b0);
    #1;
    total++;
    if (count !== 2'd2 || fflags !== 5'b00101) begin
      bad++;
      $display("FAIL reset_prefill count=%0d fflags=%b required 2/00101", count, fflags);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (count !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || fflags !== 5'b0) begin
      bad++;
      $display("FAIL reset_async count=%0d in_ready=%b out_valid=%b fflags=%b required 0/1/0/00000",
               count, bus.in_ready, bus.out_valid, fflags);
    end
    sb.delete();
    m_ff = 5'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h7F, 23'h0, 5'b0);
    cycle(pp, pu, gw, gf, ew, ef);
    drive(1'b0, 1'b0, 8'h0, 23'h0, 5'b0);
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h3F80_0000 || count !== 2'd1) begin
      bad++;
      $display("FAIL single_head valid=%b result=%h count=%0d required 1/3f800000/1",
               bus.out_valid, bus.out_result, count);
    end
    cycle(pp, pu, gw, gf, ew, ef);
    if (pp) begin
      total++;
      if (gw !== ew || gf !== ef) begin
        bad++;
        $display("FAIL single_pop got=%h/%b required %h/%b", gw, gf, ew, ef);
      end
    end
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || count !== 2'd0) begin
      bad++;
      $display("FAIL single_drained valid=%b count=%0d required 0/0", bus.out_valid, count);
    end
  endtask

  task automatic test_fill();
    int idx = 0;
    int n   = 0;
    bus.out_ready = 1'b0;
    repeat (2) begin
      drive(1'b1, fw(idx)[31], fw(idx)[30:23], fw(idx)[22:0], ff(idx));
      cycle(pp, pu, gw, gf, ew, ef);
      idx++;
    end
    drive(1'b1, fw(idx)[31], fw(idx)[30:23], fw(idx)[22:0], ff(idx));
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || count !== 2'd2) begin
      bad++;
      $display("FAIL fill_full in_ready=%b count=%0d required 0/2", bus.in_ready, count);
    end
    repeat (3) begin
      cycle(pp, pu, gw, gf, ew, ef);
      total++;
      if (gw !== sb[0][31:0] || count !== 2'd2) begin
        bad++;
        $display("FAIL fill_head_hold result=%h count=%0d required %h/2", gw, count, sb[0][31:0]);
      end
    end
    total++;
    if (fflags !== m_ff) begin
      bad++;
      $display("FAIL fill_blocked_flags fflags=%b required %b", fflags, m_ff);
    end
    bus.out_ready = 1'b1;
    while ((idx < 10 || sb.size() != 0) && n < 60) begin
      if (idx < 10) drive(1'b1, fw(idx)[31], fw(idx)[30:23], fw(idx)[22:0], ff(idx));
      else          drive(1'b0, 1'b0, 8'h0, 23'h0, 5'b0);
      cycle(pp, pu, gw, gf, ew, ef);
      if (pu) idx++;
      if (pp) begin
        total++;
        if (gw !== ew || gf !== ef) begin
          bad++;
          $display("FAIL fill_drain got=%h/%b required %h/%b", gw, gf, ew, ef);
        end
      end
      n++;
    end
    total++;
    if (idx != 10 || sb.size() != 0 || count !== 2'd0) begin
      bad++;
      $display("FAIL fill_timeout pushed=%0d left=%0d count=%0d required 10/0/0", idx, sb.size(), count);
    end
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    bus.out_ready = 1'b0;
    drive(1'b1, fw(20)[31], fw(20)[30:23], fw(20)[22:0], ff(20));
    cycle(pp, pu, gw, gf, ew, ef);
    bus.out_ready = 1'b1;
    for (int i = 21; i < 29; i++) begin
      drive(1'b1, fw(i)[31], fw(i)[30:23], fw(i)[22:0], ff(i));
      cycle(pp, pu, gw, gf, ew, ef);
      if (pp) begin
        pops++;
        total++;
        if (gw !== ew || gf !== ef) begin
          bad++;
          $display("FAIL b2b_pop got=%h/%b required %h/%b", gw, gf, ew, ef);
        end
      end
      total++;
      if (count !== 2'd1) begin
        bad++;
        $display("FAIL b2b_count count=%0d required 1", count);
      end
    end
    drive(1'b0, 1'b0, 8'h0, 23'h0, 5'b0);
    cycle(pp, pu, gw, gf, ew, ef);
    if (pp) begin
      pops++;
      total++;
      if (gw !== ew || gf !== ef) begin
        bad++;
        $display("FAIL b2b_last got=%h/%b required %h/%b", gw, gf, ew, ef);
      end
    end
    total++;
    if (pops != 9 || count !== 2'd0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_total pops=%0d count=%0d valid=%b required 9/0/0", pops, count, bus.out_valid);
    end
  endtask

  task automatic test_nan();
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 8'hFF, 23'h12345, 5'b10000);
    cycle(pp, pu, gw, gf, ew, ef);
    drive(1'b1, 1'b1, 8'hFF, 23'h12345, 5'b00000);
    cycle(pp, pu, gw, gf, ew, ef);
    drive(1'b0, 1'b0, 8'h0, 23'h0, 5'b0);
    #1;
    total++;
    if (bus.out_result !== 32'h7FC0_0000 || bus.out_flags !== 5'b10000) begin
      bad++;
      $display("FAIL nan_canon result=%h flags=%b required 7fc00000/10000", bus.out_result, bus.out_flags);
    end
    bus.out_ready = 1'b1;
    cycle(pp, pu, gw, gf, ew, ef);
    if (pp) begin
      total++;
      if (gw !== ew || gf !== ef) begin
        bad++;
        $display("FAIL nan_pop got=%h/%b required %h/%b", gw, gf, ew, ef);
      end
    end
    #1;
    total++;
    if (bus.out_result !== 32'hFF81_2345 || bus.out_flags !== 5'b00000) begin
      bad++;
      $display("FAIL nan_passthru result=%h flags=%b required ff812345/00000", bus.out_result, bus.out_flags);
    end
    cycle(pp, pu, gw, gf, ew, ef);
  endtask

  task automatic test_sticky();
    bus.out_ready = 1'b1;
    fflags_clr = 1'b1;
    drive(1'b0, 1'b0, 8'h0, 23'h0, 5'b0);
    cycle(pp, pu, gw, gf, ew, ef);
    fflags_clr = 1'b0;
    #1;
    total++;
    if (fflags !== 5'b0) begin
      bad++;
      $display("FAIL sticky_clr fflags=%b required 00000", fflags);
    end
    drive(1'b1, 1'b0, 8'h10, 23'h5, 5'b00010);
    cycle(pp, pu, gw, gf, ew, ef);
    drive(1'b1, 1'b0, 8'h11, 23'h6, 5'b01000);
    cycle(pp, pu, gw, gf, ew, ef);
    if (pp) begin
      total++;
      if (gw !== ew || gf !== ef) begin
        bad++;
        $display("FAIL sticky_pop got=%h/%b required %h/%b", gw, gf, ew, ef);
      end
    end
    drive(1'b0, 1'b0, 8'h0, 23'h0, 5'b0);
    #1;
    total++;
    if (fflags !== 5'b01010) begin
      bad++;
      $display("FAIL sticky_accum fflags=%b required 01010", fflags);
    end
    fflags_clr = 1'b1;
    drive(1'b1, 1'b0, 8'h12, 23'h7, 5'b00001);
    cycle(pp, pu, gw, gf, ew, ef);
    fflags_clr = 1'b0;
    drive(1'b0, 1'b0, 8'h0, 23'h0, 5'b0);
    #1;
    total++;
    if (fflags !== 5'b00001 || fflags !== m_ff) begin
      bad++;
      $display("FAIL sticky_clr_push fflags=%b required 00001", fflags);
    end
    for (int i = 0; i < 4 && sb.size() != 0; i++) begin
      cycle(pp, pu, gw, gf, ew, ef);
      if (pp) begin
        total++;
        if (gw !== ew || gf !== ef) begin
          bad++;
          $display("FAIL sticky_drain got=%h/%b required %h/%b", gw, gf, ew, ef);
        end
      end
    end
    total++;
    if (fflags !== 5'b00001 || count !== 2'd0) begin
      bad++;
      $display("FAIL sticky_no_pop_accum fflags=%b count=%0d required 00001/0", fflags, count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    fflags_clr = 1'b0;
    m_ff       = 5'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h0, 23'h0, 5'b0);
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_nan();
    test_sticky();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
